// File: rtl/key_pkg.sv
// key_pkg: key-gesture FSM encoding, default timing constants and counter sizing,
// shared by the decoder and the led_ctrl-side logic.
package key_pkg;

    localparam int unsigned LONG_CNT_DEF   = 50_000_000;
    localparam int unsigned GAP_CNT_DEF    = 12_500_000;
    localparam int unsigned REPEAT_CNT_DEF = 10_000_000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    typedef struct packed {
        logic short_p;
        logic double_p;
        logic long_p;
        logic repeat_p;
    } key_ev_t;

    // Width that holds (largest limit - 1); never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_timer.sv
// key_timer: shared state counter; saturates at limit so it never wraps, done flags terminal count.
module key_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;

    assign done = (cnt_q == limit);

    always_comb cnt_d = clr ? '0 : (done ? cnt_q : cnt_q + W'(1));

    always_ff @(posedge clk) begin
        cnt_q <= reset ? '0 : cnt_d;
    end

endmodule

// File: rtl/key_press_decoder.sv
// key_press_decoder: turns debounced key edges into short/double/long/repeat pulses
// using one FSM and a single counter cleared on every state change.
module key_press_decoder
    import key_pkg::*;
#(
    parameter int unsigned LONG_CNT   = LONG_CNT_DEF,
    parameter int unsigned GAP_CNT    = GAP_CNT_DEF,
    parameter int unsigned REPEAT_CNT = REPEAT_CNT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic key_flag,
    input  logic key_state,
    output logic ev_short,
    output logic ev_double,
    output logic ev_long,
    output logic ev_repeat,
    output logic key_held
);

    localparam int unsigned W = cnt_width(LONG_CNT, GAP_CNT, REPEAT_CNT);

    logic [2:0]   state_q, state_d;
    key_ev_t      ev_q, ev_d;
    logic [W-1:0] limit;
    logic         done, clr, press, rel;

    assign press = key_flag && !key_state;
    assign rel   = key_flag && key_state;

    always_comb begin
        state_d = state_q;
        ev_d    = '0;
        case (state_q)
            ST_IDLE:   if (press) state_d = ST_PRESS1;
            ST_PRESS1: begin
                if (rel) state_d = ST_WAIT2;
                else if (done) begin
                    state_d     = ST_LONG;
                    ev_d.long_p = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (press) state_d = ST_PRESS2;
                else if (done) begin
                    state_d      = ST_IDLE;
                    ev_d.short_p = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (rel) begin
                    state_d       = ST_IDLE;
                    ev_d.double_p = 1'b1;
                end else if (done) begin
                    state_d     = ST_LONG;
                    ev_d.long_p = 1'b1;
                end
            end
            ST_LONG: begin
                if (rel) state_d = ST_IDLE;
                else if (done) ev_d.repeat_p = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        limit = (state_q == ST_WAIT2) ? W'(GAP_CNT - 1) :
                (state_q == ST_LONG)  ? W'(REPEAT_CNT - 1) :
                (state_q == ST_IDLE)  ? '0 : W'(LONG_CNT - 1);
    end

    // LONG restarts the count after each repeat tick to keep the period fixed.
    assign clr = (state_d != state_q) || ((state_q == ST_LONG) && done);

    key_timer #(.W(W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .limit (limit),
        .done  (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ev_q    <= '0;
        end else begin
            state_q <= state_d;
            ev_q    <= ev_d;
        end
    end

    assign ev_short  = ev_q.short_p;
    assign ev_double = ev_q.double_p;
    assign ev_long   = ev_q.long_p;
    assign ev_repeat = ev_q.repeat_p;
    assign key_held  = (state_q == ST_PRESS1) || (state_q == ST_PRESS2) || (state_q == ST_LONG);

endmodule

// File: tb/tb_key_press_decoder.sv
// tb_key_press_decoder: directed gesture sequences with hand-computed event timing.
module tb_key_press_decoder;

    localparam logic [3:0] NONE = 4'b0000;
    localparam logic [3:0] SHRT = 4'b1000;
    localparam logic [3:0] DBL  = 4'b0100;
    localparam logic [3:0] LNG  = 4'b0010;
    localparam logic [3:0] REP  = 4'b0001;

    logic clk = 1'b0;
    logic reset, key_flag, key_state;
    logic ev_short, ev_double, ev_long, ev_repeat, key_held;
    logic [3:0] ev;
    int passed = 0;
    int total  = 0;

    key_press_decoder #(.LONG_CNT(20), .GAP_CNT(8), .REPEAT_CNT(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_flag  (key_flag),
        .key_state (key_state),
        .ev_short  (ev_short),
        .ev_double (ev_double),
        .ev_long   (ev_long),
        .ev_repeat (ev_repeat),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    assign ev = {ev_short, ev_double, ev_long, ev_repeat};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic flag(input logic st);
        key_flag  = 1'b1;
        key_state = st;
        step();
        key_flag  = 1'b0;
    endtask

    task automatic run(input string tag, input int n, input int at, input logic [3:0] e);
        for (int i = 1; i <= n; i++) begin
            step();
            check(tag, ev, (i == at) ? e : NONE);
        end
    endtask

    initial begin
        reset = 1'b1; key_flag = 1'b0; key_state = 1'b1;
        repeat (3) step();
        check("reset_ev", ev, NONE);
        check("reset_held", {3'b0, key_held}, 4'b0);
        reset = 1'b0;
        run("idle", 3, 0, NONE);

        flag(1'b0);
        check("s1_press_held", {3'b0, key_held}, 4'b1);
        run("s1_hold", 4, 0, NONE);
        flag(1'b1);
        check("s1_release", {ev[3:1], key_held}, 4'b0);
        run("s1_short", 10, 8, SHRT);

        flag(1'b0);
        run("s2_hold1", 4, 0, NONE);
        flag(1'b1);
        run("s2_gap", 2, 0, NONE);
        flag(1'b0);
        check("s2_press2_ev", ev, NONE);
        check("s2_press2_held", {3'b0, key_held}, 4'b1);
        run("s2_hold2", 3, 0, NONE);
        flag(1'b1);
        check("s2_double", ev, DBL);
        check("s2_double_held", {3'b0, key_held}, 4'b0);
        run("s2_no_short", 10, 0, NONE);

        flag(1'b0);
        for (int i = 1; i <= 31; i++) begin
            step();
            check("s3_long_ev", ev, (i == 20) ? LNG : (i == 25 || i == 30) ? REP : NONE);
            check("s3_long_held", {3'b0, key_held}, 4'b1);
        end
        flag(1'b1);
        check("s3_release_ev", ev, NONE);
        check("s3_release_held", {3'b0, key_held}, 4'b0);
        run("s3_after", 6, 0, NONE);

        flag(1'b0);
        run("s4_hold", 19, 0, NONE);
        flag(1'b1);
        check("s4_release_wins", ev, NONE);
        check("s4_release_held", {3'b0, key_held}, 4'b0);
        run("s4_short", 10, 8, SHRT);

        flag(1'b0);
        run("s5_hold", 4, 0, NONE);
        flag(1'b1);
        run("s5_gap", 2, 0, NONE);
        reset = 1'b1;
        step();
        check("s5_reset_ev", ev, NONE);
        check("s5_reset_held", {3'b0, key_held}, 4'b0);
        reset = 1'b0;
        run("s5_discard", 12, 0, NONE);
        flag(1'b0);
        run("s5_hold2", 4, 0, NONE);
        flag(1'b1);
        run("s5_short", 10, 8, SHRT);

        flag(1'b1);
        check("s6_stray_ev", ev, NONE);
        check("s6_stray_held", {3'b0, key_held}, 4'b0);
        run("s6_idle", 10, 0, NONE);
        flag(1'b0);
        run("s6_hold", 2, 0, NONE);
        flag(1'b0);
        check("s6_dup_ev", ev, NONE);
        check("s6_dup_held", {3'b0, key_held}, 4'b1);
        run("s6_hold2", 1, 0, NONE);
        flag(1'b0);
        run("s6_long", 15, 15, LNG);
        flag(1'b1);
        check("s6_release", ev, NONE);
        run("s6_after", 6, 0, NONE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/key_press_decoder.md
KEY_PRESS_DECODER -- requirements
Module: key_press_decoder

Interface
REQ-001 SHALL have parameter LONG_CNT, default 50_000_000: press duration in clk cycles that qualifies as a long press (1 s at 50 MHz).
REQ-002 SHALL have parameter GAP_CNT, default 12_500_000: maximum release-to-press gap in cycles for a double click (250 ms).
REQ-003 SHALL have parameter REPEAT_CNT, default 10_000_000: period in cycles of auto-repeat pulses while a long press is held.
REQ-004 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port key_flag  input  1  one-cycle pulse from the debounce stage, marking a debounced edge.
REQ-007 SHALL have port key_state  input  1  debounced key level; 0 = pressed, 1 = released.
REQ-008 SHALL have port ev_short  output  1  one-cycle pulse: single short click.
REQ-009 SHALL have port ev_double  output  1  one-cycle pulse: double click.
REQ-010 SHALL have port ev_long  output  1  one-cycle pulse: long-press threshold reached.
REQ-011 SHALL have port ev_repeat  output  1  one-cycle pulse: auto-repeat tick during a long press.
REQ-012 SHALL have port key_held  output  1  level; 1 while the decoder is in PRESS1, PRESS2 or LONG.

Function
REQ-013 SHALL define a press as key_flag=1 with key_state=0, and a release as key_flag=1 with key_state=1.
REQ-014 SHALL implement the FSM states IDLE, PRESS1, WAIT2, PRESS2 and LONG, plus one shared cycle counter that is cleared on every state change.
REQ-015 IDLE SHALL go to PRESS1 on a press; all other inputs SHALL be ignored in IDLE.
REQ-016 PRESS1 SHALL go to WAIT2 on a release when the counter is below LONG_CNT-1.
REQ-017 PRESS1 SHALL pulse ev_long and go to LONG when the counter reaches LONG_CNT-1.
REQ-018 WAIT2 SHALL go to PRESS2 on a press.
REQ-019 WAIT2 SHALL pulse ev_short and go to IDLE when the counter reaches GAP_CNT-1 with no press.
REQ-020 PRESS2 SHALL pulse ev_double and go to IDLE on a release.
REQ-021 PRESS2 SHALL pulse ev_long (no ev_double) and go to LONG when the counter reaches LONG_CNT-1.
REQ-022 LONG SHALL pulse ev_repeat every REPEAT_CNT cycles after entry, and SHALL go to IDLE on a release with no event.
REQ-023 Every event output SHALL be registered and SHALL assert exactly one cycle, on the clock edge that performs the triggering transition.
REQ-024 At most one event output SHALL be high in any cycle.
REQ-025 Timeout and release in the same cycle: release SHALL win in PRESS1 and PRESS2; press SHALL win in WAIT2.
REQ-026 A press flag while already pressed, or a release flag while released, SHALL be ignored.
REQ-027 The counter width SHALL be $clog2 of the largest parameter, and the counter SHALL never wrap within a state.
REQ-028 ev_short latency SHALL be exactly GAP_CNT cycles after the release edge.

Reset
REQ-029 While reset=1 at a clk edge, the FSM SHALL be IDLE, the counter 0, and all outputs 0.
REQ-030 A reset asserted mid-press or mid-gap SHALL discard the pending gesture with no event.
REQ-031 After reset, the first gesture SHALL require a fresh press flag.

Structure
REQ-032 The state encoding and the default timing constants SHALL live in shared package key_pkg, reused by led_ctrl-side logic.
REQ-033 The counter plus terminal-count compare SHALL be a sub-module key_timer (inputs clr and limit; output done).
REQ-034 The decoder SHALL sit between key_filter and led_ctrl in key_led and SHALL replace the raw key_flag&&~key_state gating.

Verification (LONG_CNT=20, GAP_CNT=8, REPEAT_CNT=5)
REQ-035 Press, release after 5 cycles, idle -> ev_short exactly once, 8 cycles after release; no other event.
REQ-036 Press 5 cycles, release, press after 3 cycles, release after 4 -> ev_double once, on the second release edge; no ev_short.
REQ-037 Press held 32 cycles -> ev_long at cycle 20 after press, ev_repeat at cycles 25 and 30, nothing on release; key_held=1 throughout the hold.
REQ-038 Release arrives in the same cycle PRESS1 would time out -> WAIT2 entered, no ev_long, ev_short 8 cycles later.
REQ-039 Reset pulsed 2 cycles after a release in WAIT2 -> no event, all outputs 0; next press/release pair yields a normal ev_short.
REQ-040 Duplicate press flags during PRESS1 and a stray release flag in IDLE -> state and outputs unchanged.
